core_insn_loader: RTL and testbench

- Per-core receiving end of the scheduler→core instruction-load protocol.
- Consumes the per-core Start bit, Insn_Load_Counter, Insn_Data and the Init_R0 slice.
- Assembles instruction frames into the core's local instruction memory, captures the initial R0, launches execution and drives the core's Ready bit back to the scheduler.
- Sits at the front of every core, between the scheduler buses and the core pipeline/imem.

---
 rtl/core_insn_loader_pkg.sv | 24 ++
 rtl/core_insn_loader_ptr.sv | 81 ++++++++
 rtl/core_insn_loader.sv | 194 +++++++++++++++++++
 tb/tb_core_insn_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_insn_loader_pkg.sv
// Shared definitions for the per-core instruction loader.
//
// Holds the default bus/timing geometry of the scheduler->core load protocol
// and the loader state encoding. The numeric defaults here seed the module
// parameters of core_insn_loader and core_insn_loader_ptr.
package core_insn_loader_pkg;

    localparam int CIL_NUM_OF_CORES   = 4;
    localparam int CIL_INSN_LOAD_TIME = 4;   // bus parts per instruction frame
    localparam int CIL_INSN_BUS_WIDTH = 32;  // one part == one imem word
    localparam int CIL_LOAD_CNT_WIDTH = 2;   // clog2(CIL_INSN_LOAD_TIME)
    localparam int CIL_REG_WIDTH      = 8;
    localparam int CIL_IMEM_DEPTH     = 64;
    localparam int CIL_IMEM_AW        = $clog2(CIL_IMEM_DEPTH);

    // Loader state encoding; values are visible on debug taps, keep them fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_RUN    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/core_insn_loader_ptr.sv
// Part counter, imem word pointer and overflow tracking for the loader.
//
// Ports:
//   clk, reset   core clock, asynchronous active-low reset
//   load_first   first part of a new load (pointer/counter restart at 0)
//   load_part    further part accepted while loading
//   part_cnt     index of the next expected part within the frame
//   word_ptr     imem address of the next part (valid while loading)
//   frame_cnt    completed frames in the current load
//   full         last imem word has been written; further parts are dropped
module core_insn_loader_ptr
    import core_insn_loader_pkg::*;
#(
    parameter int INSN_LOAD_TIME = CIL_INSN_LOAD_TIME,
    parameter int LOAD_CNT_WIDTH = CIL_LOAD_CNT_WIDTH,
    parameter int IMEM_DEPTH     = CIL_IMEM_DEPTH,
    parameter int IMEM_AW        = CIL_IMEM_AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_first,
    input  logic                      load_part,
    output logic [LOAD_CNT_WIDTH-1:0] part_cnt,
    output logic [IMEM_AW-1:0]        word_ptr,
    output logic [IMEM_AW-1:0]        frame_cnt,
    output logic                      full
);

    localparam logic [LOAD_CNT_WIDTH-1:0] PART_LAST = LOAD_CNT_WIDTH'(INSN_LOAD_TIME - 1);
    localparam logic [IMEM_AW-1:0]        PTR_LAST  = IMEM_AW'(IMEM_DEPTH - 1);

    logic [LOAD_CNT_WIDTH-1:0] part_cnt_reg;
    logic [LOAD_CNT_WIDTH-1:0] part_base;
    logic [IMEM_AW-1:0]        word_ptr_reg;
    logic [IMEM_AW-1:0]        ptr_base;
    logic [IMEM_AW-1:0]        frame_cnt_reg;
    logic [IMEM_AW-1:0]        frame_base;
    logic                      full_reg;
    logic                      full_base;
    logic                      part_wrap;
    logic                      ptr_last;
    logic                      advance;

    // A new load behaves as if all tracking state were zero, so the first
    // part is counted with the same arithmetic as every later one.
    always_comb begin
        advance    = load_first | load_part;
        part_base  = load_first ? '0 : part_cnt_reg;
        ptr_base   = load_first ? '0 : word_ptr_reg;
        frame_base = load_first ? '0 : frame_cnt_reg;
        full_base  = load_first ? 1'b0 : full_reg;
        part_wrap  = (part_base == PART_LAST);
        ptr_last   = (ptr_base == PTR_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            part_cnt_reg  <= '0;
            word_ptr_reg  <= '0;
            frame_cnt_reg <= '0;
            full_reg      <= 1'b0;
        end else if (advance) begin
            part_cnt_reg  <= part_wrap ? '0 : part_base + LOAD_CNT_WIDTH'(1);
            frame_cnt_reg <= frame_base + IMEM_AW'(part_wrap);
            // Pointer parks on the last word instead of wrapping; parts past
            // it keep counting so frame alignment is preserved.
            full_reg      <= full_base | ptr_last;
            if (!full_base && !ptr_last) begin
                word_ptr_reg <= ptr_base + IMEM_AW'(1);
            end else begin
                word_ptr_reg <= ptr_base;
            end
        end
    end

    assign part_cnt  = part_cnt_reg;
    assign word_ptr  = word_ptr_reg;
    assign frame_cnt = frame_cnt_reg;
    assign full      = full_reg;

endmodule

// File: rtl/core_insn_loader.sv
// Per-core receiving end of the scheduler->core instruction-load protocol.
//
// Assembles instruction frames into the core's imem, captures the initial
// R0, launches execution and drives the core's Ready bit.
//
// Ports:
//   clk, reset         core clock, asynchronous active-low reset
//   start              Start[CORE_ID] from the scheduler
//   insn_load_counter  part index accompanying insn_data
//   insn_data          one frame part
//   init_r0_vect       per-core "R0 present" flags
//   init_r0            all cores' R0 slices
//   ready              1 = idle/accepting, 0 = core running
//   imem_we/addr/wdata combinational imem write port (zero-latency writes)
//   r0_we, r0_value    initial R0 write into the core register file
//   exec_start         one-cycle pulse, core begins at PC 0
//   exec_done          core finished (pulse or level)
//   proto_err          sticky protocol/overflow error, cleared by reset only
//
// Build option: define LOADER_CNT_CHECK_EN to compare insn_load_counter
// against the internal part counter; a mismatch drops the part, flags
// proto_err and aborts the load. Without it insn_load_counter is ignored.
module core_insn_loader
    import core_insn_loader_pkg::*;
#(
    parameter int  CORE_ID        = 0,
    parameter int  NUM_OF_CORES   = CIL_NUM_OF_CORES,
    parameter int  INSN_LOAD_TIME = CIL_INSN_LOAD_TIME,
    parameter int  INSN_BUS_WIDTH = CIL_INSN_BUS_WIDTH,
    parameter int  LOAD_CNT_WIDTH = CIL_LOAD_CNT_WIDTH,
    parameter int  REG_WIDTH      = CIL_REG_WIDTH,
    parameter int  IMEM_DEPTH     = CIL_IMEM_DEPTH,
    localparam int IMEM_AW        = $clog2(IMEM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [LOAD_CNT_WIDTH-1:0]       insn_load_counter,
    input  logic [INSN_BUS_WIDTH-1:0]       insn_data,
    input  logic [NUM_OF_CORES-1:0]         init_r0_vect,
    input  logic [NUM_OF_CORES*REG_WIDTH-1:0] init_r0,
    output logic                            ready,
    output logic                            imem_we,
    output logic [IMEM_AW-1:0]              imem_addr,
    output logic [INSN_BUS_WIDTH-1:0]       imem_wdata,
    output logic                            r0_we,
    output logic [REG_WIDTH-1:0]            r0_value,
    output logic                            exec_start,
    input  logic                            exec_done,
    output logic                            proto_err
);

    loader_state_t             state_reg, state_next;
    logic                      ready_reg, ready_next;
    logic                      r0_we_reg, r0_we_next;
    logic [REG_WIDTH-1:0]      r0_value_reg, r0_value_next;
    logic                      exec_start_reg, exec_start_next;
    logic                      proto_err_reg, proto_err_next;

    logic [LOAD_CNT_WIDTH-1:0] part_cnt;
    logic [LOAD_CNT_WIDTH-1:0] expected_part;
    logic [IMEM_AW-1:0]        word_ptr;
    logic [IMEM_AW-1:0]        frame_cnt;
    logic                      full;
    logic                      cnt_ok;
    logic                      load_first;
    logic                      load_part;
    logic                      unused_ok;

    // From IDLE the first part is always index 0, whatever the counter was
    // left at by an aborted load.
    assign expected_part = (state_reg == ST_IDLE) ? '0 : part_cnt;

`ifdef LOADER_CNT_CHECK_EN
    assign cnt_ok    = (insn_load_counter == expected_part);
    assign unused_ok = ^{init_r0_vect, init_r0, frame_cnt};
`else
    assign cnt_ok    = 1'b1;
    assign unused_ok = ^{init_r0_vect, init_r0, frame_cnt, insn_load_counter, expected_part};
`endif

    assign load_first = start && (state_reg == ST_IDLE) && cnt_ok;
    assign load_part  = start && (state_reg == ST_LOAD) && cnt_ok;

    core_insn_loader_ptr #(
        .INSN_LOAD_TIME (INSN_LOAD_TIME),
        .LOAD_CNT_WIDTH (LOAD_CNT_WIDTH),
        .IMEM_DEPTH     (IMEM_DEPTH),
        .IMEM_AW        (IMEM_AW)
    ) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .load_first (load_first),
        .load_part  (load_part),
        .part_cnt   (part_cnt),
        .word_ptr   (word_ptr),
        .frame_cnt  (frame_cnt),
        .full       (full)
    );

    // Write port is combinational so the part lands in imem in the same
    // cycle it is on the bus. Gating with reset abandons an in-flight write
    // the moment reset asserts.
    assign imem_we    = reset && (load_first || (load_part && !full));
    assign imem_addr  = (state_reg == ST_IDLE) ? '0 : word_ptr;
    assign imem_wdata = insn_data;

    always_comb begin
        state_next      = state_reg;
        ready_next      = ready_reg;
        r0_we_next      = 1'b0;
        r0_value_next   = r0_value_reg;
        exec_start_next = 1'b0;
        proto_err_next  = proto_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (cnt_ok) begin
                        state_next = ST_LOAD;
                        r0_we_next = init_r0_vect[CORE_ID];
                        if (init_r0_vect[CORE_ID]) begin
                            r0_value_next = init_r0[CORE_ID*REG_WIDTH +: REG_WIDTH];
                        end
                    end else begin
                        proto_err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (start) begin
                    if (!cnt_ok) begin
                        proto_err_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else if (full) begin
                        proto_err_next = 1'b1;   // part dropped, keep framing
                    end
                end else if (part_cnt == '0) begin
                    // Ready drops on the same edge exec_start rises.
                    state_next      = ST_LAUNCH;
                    exec_start_next = 1'b1;
                    ready_next      = 1'b0;
                end else begin
                    proto_err_next = 1'b1;       // partial frame: no launch
                    state_next     = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_RUN;             // exec_done ignored here
                if (start) begin
                    proto_err_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (start) begin
                    proto_err_next = 1'b1;
                end
                if (exec_done) begin
                    state_next = ST_IDLE;
                    ready_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b1;
            r0_we_reg      <= 1'b0;
            r0_value_reg   <= '0;
            exec_start_reg <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= ready_next;
            r0_we_reg      <= r0_we_next;
            r0_value_reg   <= r0_value_next;
            exec_start_reg <= exec_start_next;
            proto_err_reg  <= proto_err_next;
        end
    end

    assign ready      = ready_reg;
    assign r0_we      = r0_we_reg;
    assign r0_value   = r0_value_reg;
    assign exec_start = exec_start_reg;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_core_insn_loader.sv
// Directed testbench for core_insn_loader. Two instances share stimulus:
// u_dut_a (CORE_ID=1, 64-word imem) and u_dut_b (CORE_ID=0, 8-word imem).
module tb_core_insn_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        exec_done = 1'b0;
    logic [1:0]  cnt = 2'd0;
    logic [31:0] data = 32'd0;
    logic [3:0]  init_r0_vect = 4'b0010;
    logic [31:0] init_r0 = 32'h0000_5A00;

    logic        ready_a, imem_we_a, r0_we_a, exec_start_a, proto_err_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [7:0]  r0_val_a;
    logic        ready_b, imem_we_b, r0_we_b, exec_start_b, proto_err_b;
    logic [2:0]  addr_b;
    logic [31:0] wdata_b;
    logic [7:0]  r0_val_b;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:7];
    int          wr_a = 0;
    int          wr_b = 0;
    int          errors = 0;
    int          checks = 0;

    core_insn_loader #(.CORE_ID(1), .IMEM_DEPTH(64)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .insn_load_counter(cnt),
        .insn_data(data), .init_r0_vect(init_r0_vect), .init_r0(init_r0),
        .ready(ready_a), .imem_we(imem_we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .r0_we(r0_we_a), .r0_value(r0_val_a),
        .exec_start(exec_start_a), .exec_done(exec_done), .proto_err(proto_err_a)
    );

    core_insn_loader #(.CORE_ID(0), .IMEM_DEPTH(8)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .insn_load_counter(cnt),
        .insn_data(data), .init_r0_vect(init_r0_vect), .init_r0(init_r0),
        .ready(ready_b), .imem_we(imem_we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .r0_we(r0_we_b), .r0_value(r0_val_b),
        .exec_start(exec_start_b), .exec_done(exec_done), .proto_err(proto_err_b)
    );

    always #5 clk = ~clk;

    // imem models for both instances; write counters are free-running.
    always @(posedge clk) begin
        if (imem_we_a) begin
            mem_a[addr_a] <= wdata_a;
            wr_a <= wr_a + 1;
        end
        if (imem_we_b) begin
            mem_b[addr_b] <= wdata_b;
            wr_b <= wr_b + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; start = 1'b0; exec_done = 1'b0; cnt = 2'd0; data = 32'd0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    // Drives n consecutive start cycles with a well-formed part counter,
    // leaving start low afterwards (no extra clock).
    task automatic load_parts(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            start = 1'b1; data = base + 32'(i); cnt = 2'(i % 4);
            step();
        end
        start = 1'b0;
        $display("load: %0d parts from base %h", n, base);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        step();
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
        checks++; if (r0_we_a !== 1'b0) begin errors++; $display("FAIL reset_r0_we: got %b expected 0", r0_we_a); end
        checks++; if (r0_val_a !== 8'h00) begin errors++; $display("FAIL reset_r0_value: got %h expected 00", r0_val_a); end
        checks++; if (exec_start_a !== 1'b0) begin errors++; $display("FAIL reset_exec_start: got %b expected 0", exec_start_a); end
        checks++; if (proto_err_a !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err_a); end
        start = 1'b1; #1;
        checks++; if (imem_we_a !== 1'b0) begin errors++; $display("FAIL reset_we_gated: got %b expected 0", imem_we_a); end
        reset = 1'b1; data = 32'h1234_5678; #1;
        checks++; if (imem_we_a !== 1'b1) begin errors++; $display("FAIL idle_we: got %b expected 1", imem_we_a); end
        reset = 1'b0; #1;
        checks++; if (imem_we_a !== 1'b0) begin errors++; $display("FAIL async_we_drop: got %b expected 0", imem_we_a); end
        start = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int base;
        apply_reset();
        base = wr_a;
        start = 1'b1; data = 32'hA0A0_0000; cnt = 2'd0; #1;
        checks++; if (imem_we_a !== 1'b1 || addr_a !== 6'd0) begin errors++; $display("FAIL first_write: we=%b addr=%0d expected we=1 addr=0", imem_we_a, addr_a); end
        step();
        checks++; if (r0_we_a !== 1'b1 || r0_val_a !== 8'h5A) begin errors++; $display("FAIL r0_capture: we=%b val=%h expected we=1 val=5a", r0_we_a, r0_val_a); end
        checks++; if (r0_we_b !== 1'b0) begin errors++; $display("FAIL r0_absent: got %b expected 0", r0_we_b); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", ready_a); end
        data = 32'hA0A0_0001; cnt = 2'd1; step();
        checks++; if (r0_we_a !== 1'b0) begin errors++; $display("FAIL r0_we_pulse: got %b expected 0", r0_we_a); end
        data = 32'hA0A0_0002; cnt = 2'd2; step();
        data = 32'hA0A0_0003; cnt = 2'd3; step();
        start = 1'b0;
        checks++; if (exec_start_a !== 1'b0) begin errors++; $display("FAIL early_exec_start: got %b expected 0", exec_start_a); end
        step();
        checks++; if (exec_start_a !== 1'b1 || ready_a !== 1'b0) begin errors++; $display("FAIL launch: exec_start=%b ready=%b expected 1 0", exec_start_a, ready_a); end
        step();
        checks++; if (exec_start_a !== 1'b0) begin errors++; $display("FAIL exec_start_width: got %b expected 0", exec_start_a); end
        checks++; if (wr_a - base !== 4) begin errors++; $display("FAIL frame_writes: got %0d expected 4", wr_a - base); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_a[i] !== 32'hA0A0_0000 + 32'(i)) begin errors++; $display("FAIL frame_word%0d: got %h expected %h", i, mem_a[i], 32'hA0A0_0000 + 32'(i)); end
        end
        exec_done = 1'b1; step(); exec_done = 1'b0;
        checks++; if (ready_a !== 1'b1 || proto_err_a !== 1'b0) begin errors++; $display("FAIL done_ready: ready=%b err=%b expected 1 0", ready_a, proto_err_a); end
        $display("test_single_frame done");
    endtask

    task automatic test_back_to_back();
        int base;
        apply_reset();
        base = wr_a;
        load_parts(12, 32'hB000_0000);
        step();
        checks++; if (exec_start_a !== 1'b1) begin errors++; $display("FAIL b2b_launch: got %b expected 1", exec_start_a); end
        repeat (20) step();
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL b2b_run_ready: got %b expected 0", ready_a); end
        exec_done = 1'b1; step(); exec_done = 1'b0;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_done_ready: got %b expected 1", ready_a); end
        checks++; if (wr_a - base !== 12) begin errors++; $display("FAIL b2b_writes: got %0d expected 12", wr_a - base); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (mem_a[i] !== 32'hB000_0000 + 32'(i)) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, mem_a[i], 32'hB000_0000 + 32'(i)); end
        end
        checks++; if (proto_err_a !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", proto_err_a); end
        $display("test_back_to_back done");
    endtask

    task automatic test_partial();
        int base;
        apply_reset();
        base = wr_a;
        load_parts(2, 32'hD000_0000);
        step();
        checks++; if (proto_err_a !== 1'b1) begin errors++; $display("FAIL partial_err: got %b expected 1", proto_err_a); end
        checks++; if (exec_start_a !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL partial_state: exec_start=%b ready=%b expected 0 1", exec_start_a, ready_a); end
        step();
        checks++; if (exec_start_a !== 1'b0) begin errors++; $display("FAIL partial_no_launch: got %b expected 0", exec_start_a); end
        checks++; if (wr_a - base !== 2) begin errors++; $display("FAIL partial_writes: got %0d expected 2", wr_a - base); end
        start = 1'b1; data = 32'hE0E0_E0E0; cnt = 2'd0; #1;
        checks++; if (imem_we_a !== 1'b1 || addr_a !== 6'd0) begin errors++; $display("FAIL partial_idle: we=%b addr=%0d expected 1 0", imem_we_a, addr_a); end
        start = 1'b0; step();
        checks++; if (proto_err_a !== 1'b1) begin errors++; $display("FAIL partial_sticky: got %b expected 1", proto_err_a); end
        $display("test_partial done");
    endtask

    task automatic test_run_start();
        int base;
        apply_reset();
        base = wr_a;
        load_parts(4, 32'hF000_0000);
        step();
        exec_done = 1'b1; step(); exec_done = 1'b0;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL launch_done_ignored: got %b expected 0", ready_a); end
        start = 1'b1; data = 32'h9999_9999; #1;
        checks++; if (imem_we_a !== 1'b0) begin errors++; $display("FAIL run_no_write: got %b expected 0", imem_we_a); end
        step(); start = 1'b0;
        checks++; if (proto_err_a !== 1'b1 || ready_a !== 1'b0) begin errors++; $display("FAIL run_start_err: err=%b ready=%b expected 1 0", proto_err_a, ready_a); end
        exec_done = 1'b1; step(); exec_done = 1'b0;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL run_done_ready: got %b expected 1", ready_a); end
        checks++; if (wr_a - base !== 4) begin errors++; $display("FAIL run_writes: got %0d expected 4", wr_a - base); end
        $display("test_run_start done");
    endtask

    task automatic test_overflow();
        int base_b;
        apply_reset();
        base_b = wr_b;
        load_parts(12, 32'hC000_0000);
        step();
        checks++; if (exec_start_b !== 1'b1 || proto_err_b !== 1'b1) begin errors++; $display("FAIL ovf_launch: exec_start=%b err=%b expected 1 1", exec_start_b, proto_err_b); end
        checks++; if (exec_start_a !== 1'b1 || proto_err_a !== 1'b0) begin errors++; $display("FAIL ovf_big_imem: exec_start=%b err=%b expected 1 0", exec_start_a, proto_err_a); end
        checks++; if (wr_b - base_b !== 8) begin errors++; $display("FAIL ovf_writes: got %0d expected 8", wr_b - base_b); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem_b[i] !== 32'hC000_0000 + 32'(i)) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, mem_b[i], 32'hC000_0000 + 32'(i)); end
        end
        exec_done = 1'b1; step(); step(); exec_done = 1'b0;
        $display("test_overflow done");
    endtask

    task automatic test_cnt_check();
        logic [1:0] tbl [4];
        int base, exp_wr;
        logic exp_err, exp_launch;
        tbl = '{2'd0, 2'd1, 2'd3, 2'd3};
`ifdef LOADER_CNT_CHECK_EN
        exp_wr = 2; exp_err = 1'b1; exp_launch = 1'b0;
`else
        exp_wr = 4; exp_err = 1'b0; exp_launch = 1'b1;
`endif
        apply_reset();
        base = wr_a;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; data = 32'hEE00_0000 + 32'(i); cnt = tbl[i];
            step();
        end
        start = 1'b0;
        step();
        checks++; if (wr_a - base !== exp_wr) begin errors++; $display("FAIL cnt_writes: got %0d expected %0d", wr_a - base, exp_wr); end
        checks++; if (proto_err_a !== exp_err) begin errors++; $display("FAIL cnt_err: got %b expected %b", proto_err_a, exp_err); end
        checks++; if (exec_start_a !== exp_launch) begin errors++; $display("FAIL cnt_launch: got %b expected %b", exec_start_a, exp_launch); end
        checks++; if (mem_a[1] !== 32'hEE00_0001) begin errors++; $display("FAIL cnt_word1: got %h expected ee000001", mem_a[1]); end
        $display("test_cnt_check done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_partial();
        test_run_start();
        test_overflow();
        test_cnt_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
